// File: rtl/cacheline_burst_adapter.sv
// rtl/cacheline_burst_adapter.sv - cache line read/write requests to fixed-length memory bursts
// Optional last-read-line buffer is enabled by defining CBA_LAST_LINE_BUF_EN.
module cacheline_burst_adapter #(
    parameter int LINE_W   = 256,
    parameter int BEAT_W   = 64,
    parameter int OFFSET_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);
    localparam int N = LINE_W / BEAT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         address_o_q, address_o_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   line_o_q, line_o_d;
    logic [BEAT_W-1:0]   burst_o_q, burst_o_d;
    logic                read_o_q, read_o_d;
    logic                write_o_q, write_o_d;
    logic                resp_o_q, resp_o_d;

    logic [31:0]         aligned_addr;
    logic                rd_last;
    logic                wr_last;
    logic                buf_hit;
    logic [LINE_W-1:0]   hit_line;

    assign aligned_addr = address_i & ALIGN_MASK;
    assign rd_last = (state_q == READ) && resp_i && (cnt_q == LAST_BEAT);
    assign wr_last = (state_q == WRITE) && resp_i && (cnt_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        address_o_d = address_o_q;
        wline_d     = wline_q;
        line_o_d    = line_o_q;
        burst_o_d   = burst_o_q;
        read_o_d    = 1'b0;
        write_o_d   = 1'b0;
        resp_o_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (write_i) begin
                    state_d     = WRITE;
                    address_o_d = aligned_addr;
                    wline_d     = line_i;
                    burst_o_d   = line_i[BEAT_W-1:0];
                    write_o_d   = 1'b1;
                end else if (read_i) begin
                    address_o_d = aligned_addr;
                    if (buf_hit) begin
                        state_d  = DONE;
                        line_o_d = hit_line;
                        resp_o_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        read_o_d = 1'b1;
                    end
                end
            end
            READ: begin
                read_o_d = 1'b1;
                if (resp_i) begin
                    // Beats land directly in line_o so the old line survives until the first new beat.
                    for (int k = 0; k < N; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            line_o_d[k*BEAT_W +: BEAT_W] = burst_i;
                        end
                    end
                    if (rd_last) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        read_o_d = 1'b0;
                        resp_o_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                write_o_d = 1'b1;
                if (resp_i) begin
                    if (wr_last) begin
                        state_d   = DONE;
                        cnt_d     = '0;
                        write_o_d = 1'b0;
                        resp_o_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        for (int k = 0; k < N; k++) begin
                            if (cnt_d == CNT_W'(k)) begin
                                burst_o_d = wline_q[k*BEAT_W +: BEAT_W];
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            address_o_q <= '0;
            wline_q     <= '0;
            line_o_q    <= '0;
            burst_o_q   <= '0;
            read_o_q    <= 1'b0;
            write_o_q   <= 1'b0;
            resp_o_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            address_o_q <= address_o_d;
            wline_q     <= wline_d;
            line_o_q    <= line_o_d;
            burst_o_q   <= burst_o_d;
            read_o_q    <= read_o_d;
            write_o_q   <= write_o_d;
            resp_o_q    <= resp_o_d;
        end
    end

`ifdef CBA_LAST_LINE_BUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [31:0]       buf_addr_q, buf_addr_d;
    logic [LINE_W-1:0] buf_line_q, buf_line_d;

    // A completed write to the buffered address keeps the entry coherent with memory.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_line_d  = buf_line_q;
        if (rd_last) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = address_o_q;
            buf_line_d  = line_o_d;
        end else if (wr_last && buf_valid_q && (buf_addr_q == address_o_q)) begin
            buf_line_d = wline_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_line_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_line_q  <= buf_line_d;
        end
    end

    assign buf_hit  = buf_valid_q && (buf_addr_q == aligned_addr);
    assign hit_line = buf_line_q;
`else
    assign buf_hit  = 1'b0;
    assign hit_line = '0;
`endif

    assign line_o    = line_o_q;
    assign resp_o    = resp_o_q;
    assign burst_o   = burst_o_q;
    assign address_o = address_o_q;
    assign read_o    = read_o_q;
    assign write_o   = write_o_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb/tb_cacheline_burst_adapter.sv - transaction-level model and directed tests for cacheline_burst_adapter
module tb_cacheline_burst_adapter;
    logic         clk;
    logic         rst_n;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    cacheline_burst_adapter dut (
        .clk(clk), .rst_n(rst_n), .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    int n_pass = 0;
    int n_total = 0;
    int resp_cnt = 0;
    bit chk_en = 0;

    logic [255:0] m_line;
    logic [31:0]  m_addr;
    logic [63:0]  m_burst;
    logic         m_read, m_write, m_resp;
`ifdef CBA_LAST_LINE_BUF_EN
    logic         m_buf_valid;
    logic [31:0]  m_buf_addr;
    logic [255:0] m_buf_line;
`endif

    localparam logic [255:0] LINE_A = {64'h4444444444444444, 64'h3333333333333333,
                                       64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] LINE_W1 = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                        64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    localparam logic [255:0] LINE_B = {64'h0D0D0D0D0D0D0D0D, 64'h0C0C0C0C0C0C0C0C,
                                       64'h0B0B0B0B0B0B0B0B, 64'h0A0A0A0A0A0A0A0A};
    localparam logic [255:0] LINE_N = {64'h8888888888888888, 64'h7777777777777777,
                                       64'h6666666666666666, 64'h5555555555555555};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h required %h", name, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("read_o", {255'd0, read_o}, {255'd0, m_read});
            check("write_o", {255'd0, write_o}, {255'd0, m_write});
            check("resp_o", {255'd0, resp_o}, {255'd0, m_resp});
            check("address_o", {224'd0, address_o}, {224'd0, m_addr});
            check("burst_o", {192'd0, burst_o}, {192'd0, m_burst});
            check("line_o", line_o, m_line);
            if (resp_o === 1'b1) resp_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_line = '0; m_addr = '0; m_burst = '0;
        m_read = 1'b0; m_write = 1'b0; m_resp = 1'b0;
`ifdef CBA_LAST_LINE_BUF_EN
        m_buf_valid = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        tick();
        model_clear();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    // One line transaction; pat bit t is the resp_i value in the t-th cycle after acceptance.
    // abort_at >= 0 applies reset once that many beats have been transferred.
    task automatic xfer(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                        input logic [255:0] data, input logic [15:0] pat, input int abort_at);
        logic [31:0] al;
        bit hit;
        bit aborted;
        int k;
        int t;
        al = addr & 32'hFFFF_FFE0;
        hit = 1'b0;
        aborted = 1'b0;
`ifdef CBA_LAST_LINE_BUF_EN
        hit = !is_wr && m_buf_valid && (m_buf_addr == al);
`endif
        address_i = addr;
        write_i = is_wr;
        read_i = !is_wr || also_rd;
        if (is_wr) line_i = data;
        tick();
        m_addr = al;
        if (hit) begin
`ifdef CBA_LAST_LINE_BUF_EN
            m_line = m_buf_line;
`endif
        end else begin
            if (is_wr) begin
                m_write = 1'b1;
                m_burst = data[63:0];
            end else begin
                m_read = 1'b1;
            end
            k = 0;
            t = 0;
            while (k < 4 && !aborted) begin
                if (k == abort_at) begin
                    resp_i = 1'b0; rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0;
                    tick();
                    model_clear();
                    rst_n = 1'b1;
                    aborted = 1'b1;
                end else if (t >= 16) begin
                    check("beat_timeout", 256'(k), 256'd4);
                    aborted = 1'b1;
                end else begin
                    resp_i = pat[t];
                    burst_i = pat[t] ? data[k*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
                    tick();
                    if (pat[t]) begin
                        if (!is_wr) m_line[k*64 +: 64] = data[k*64 +: 64];
                        k++;
                        if (is_wr && k < 4) m_burst = data[k*64 +: 64];
                    end
                    t++;
                end
            end
            resp_i = 1'b0;
        end
        if (!aborted) begin
            m_read = 1'b0;
            m_write = 1'b0;
            m_resp = 1'b1;
`ifdef CBA_LAST_LINE_BUF_EN
            if (!is_wr) begin
                m_buf_valid = 1'b1;
                m_buf_addr = al;
                m_buf_line = m_line;
            end else if (m_buf_valid && m_buf_addr == al) begin
                m_buf_line = data;
            end
`endif
            read_i = 1'b0;
            write_i = 1'b0;
            tick();
            m_resp = 1'b0;
        end
    endtask

    initial begin
        int r0;
        rst_n = 1'b0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        line_i = '0; burst_i = '0; resp_i = 1'b0;
        do_reset();
        check("reset_line_o", line_o, 256'd0);
        check("reset_address_o", {224'd0, address_o}, 256'd0);

        r0 = resp_cnt;
        xfer(1'b0, 1'b0, 32'h0000_1234, LINE_A, 16'h000F, -1);
        check("rd1_line", line_o, LINE_A);
        check("rd1_addr", {224'd0, address_o}, {224'd0, 32'h0000_1220});
        check("rd1_resp_count", 256'(resp_cnt - r0), 256'd1);

        r0 = resp_cnt;
        xfer(1'b1, 1'b0, 32'h0000_2008, LINE_W1, 16'h0059, -1);
        check("wr_last_beat", {192'd0, burst_o}, {192'd0, 64'hDDDDDDDDDDDDDDDD});
        check("wr_line_o_kept", line_o, LINE_A);
        check("wr_resp_count", 256'(resp_cnt - r0), 256'd1);

        xfer(1'b1, 1'b1, 32'h0000_3000, LINE_B, 16'h00FF, -1);
        check("simul_addr", {224'd0, address_o}, {224'd0, 32'h0000_3000});

        resp_i = 1'b1; burst_i = 64'hDEAD;
        tick();
        resp_i = 1'b0;
        tick();
        check("stray_line_o", line_o, LINE_A);

        xfer(1'b0, 1'b0, 32'h0000_4010, LINE_N, 16'h000F, 2);
        check("abort_line_o", line_o, 256'd0);
        check("abort_read_o", {255'd0, read_o}, 256'd0);
        xfer(1'b0, 1'b0, 32'h0000_4010, LINE_N, 16'h00AA, -1);
        check("fresh_line", line_o, LINE_N);

        xfer(1'b0, 1'b0, 32'h0000_0100, LINE_B, 16'h000F, -1);
        r0 = resp_cnt;
        xfer(1'b0, 1'b0, 32'h0000_0104, LINE_B, 16'h000F, -1);
        check("buf_rd_line", line_o, LINE_B);
        check("buf_rd_resp_count", 256'(resp_cnt - r0), 256'd1);
        xfer(1'b1, 1'b0, 32'h0000_0100, LINE_W1, 16'h000F, -1);
        xfer(1'b0, 1'b0, 32'h0000_0100, LINE_W1, 16'h000F, -1);
        check("buf_after_wr_line", line_o, LINE_W1);

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end
endmodule
